// File: rtl/fire_ex3_sched_if.sv
// Handshake/bus bundle between the layer controller and the expand-3x3 sequencer.
// Optional stall_cnt member exists only when FIRE_EX3_SCHED_PERF_EN is defined.
interface fire_ex3_sched_if #(
  parameter int W_IN       = 32,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 3
);
  localparam int AW = $clog2(W_IN*W_IN*CHIN);
  localparam int WW = $clog2(KERNEL_DIM*KERNEL_DIM*CHIN);
  localparam int XW = (W_IN > 1) ? $clog2(W_IN) : 1;

  logic          start;
  logic          stall;
  logic [AW-1:0] ifm_addr;
  logic          pad_zero;
  logic [WW-1:0] w_addr;
  logic          mac_en;
  logic          mac_clr;
  logic          mac_last;
  logic          ofm_valid;
  logic [XW-1:0] ofm_x;
  logic [XW-1:0] ofm_y;
  logic          busy;
  logic          done;
`ifdef FIRE_EX3_SCHED_PERF_EN
  logic [31:0]   stall_cnt;
`endif

  modport master (
    output start, stall,
    input  ifm_addr, pad_zero, w_addr, mac_en, mac_clr, mac_last,
           ofm_valid, ofm_x, ofm_y, busy, done
`ifdef FIRE_EX3_SCHED_PERF_EN
    , input stall_cnt
`endif
  );

  modport slave (
    input  start, stall,
    output ifm_addr, pad_zero, w_addr, mac_en, mac_clr, mac_last,
           ofm_valid, ofm_x, ofm_y, busy, done
`ifdef FIRE_EX3_SCHED_PERF_EN
    , output stall_cnt
`endif
  );
endinterface

// File: rtl/fire_ex3_sched.sv
// Stall-aware sequencer for a fire-module expand-3x3 MAC array (c, kx, ky, ox, oy order).
// Define FIRE_EX3_SCHED_PERF_EN to add the saturating stall_cnt performance counter.
module fire_ex3_sched #(
  parameter int W_IN       = 32,
  parameter int CHIN       = 32,
  parameter int KERNEL_DIM = 3,
  parameter int PAD        = 1,
  parameter int MEM_LAT    = 1,
  parameter int MAC_LAT    = 1
) (
  input  logic           clk,
  input  logic           rst,
  fire_ex3_sched_if.slave sif
);
  localparam int AW = $clog2(W_IN*W_IN*CHIN);
  localparam int WW = $clog2(KERNEL_DIM*KERNEL_DIM*CHIN);
  localparam int XW = (W_IN > 1) ? $clog2(W_IN) : 1;
  localparam int KW = (KERNEL_DIM > 1) ? $clog2(KERNEL_DIM) : 1;
  localparam int CW = (CHIN > 1) ? $clog2(CHIN) : 1;
  localparam int L  = MEM_LAT + MAC_LAT;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t        state;
  logic [CW-1:0] c;
  logic [KW-1:0] kx, ky;
  logic [XW-1:0] ox, oy;
  logic [AW-1:0] ifm_addr;
  logic [WW-1:0] w_addr;
  logic          busy, done;

  logic [MEM_LAT:0]       vld_pipe, clr_pipe, pad_pipe;
  logic [L:0]             last_pipe;
  logic [L:0][XW-1:0]     x_pipe, y_pipe;

  logic          last_c, last_kx, last_ky, last_ox, last_oy;
  logic          win_first, win_last, issue, pending, in_bounds;
  int            iy, ix;
  logic [AW-1:0] ifm_addr_nxt;
  logic [WW-1:0] w_addr_nxt;

  assign last_c    = (c  == CW'(CHIN-1));
  assign last_kx   = (kx == KW'(KERNEL_DIM-1));
  assign last_ky   = (ky == KW'(KERNEL_DIM-1));
  assign last_ox   = (ox == XW'(W_IN-1));
  assign last_oy   = (oy == XW'(W_IN-1));
  assign win_first = (c == '0) && (kx == '0) && (ky == '0);
  assign win_last  = last_c && last_kx && last_ky;
  assign issue     = (state == RUN) && !sif.stall;
  // Strobes still in flight; the final ofm_valid stage itself does not hold DRAIN.
  assign pending   = |last_pipe[L-1:0];

  // Signed window coordinates so a negative row/column can never alias into the image.
  always_comb begin
    iy           = int'(oy) + int'(ky) - PAD;
    ix           = int'(ox) + int'(kx) - PAD;
    in_bounds    = (iy >= 0) && (iy < W_IN) && (ix >= 0) && (ix < W_IN);
    w_addr_nxt   = WW'((int'(ky)*KERNEL_DIM + int'(kx))*CHIN + int'(c));
    ifm_addr_nxt = '0;
    if (in_bounds) ifm_addr_nxt = AW'((iy*W_IN + ix)*CHIN + int'(c));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      c        <= '0;
      kx       <= '0;
      ky       <= '0;
      ox       <= '0;
      oy       <= '0;
      ifm_addr <= '0;
      w_addr   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sif.start) begin
            state <= RUN;
            busy  <= 1'b1;
            c     <= '0;
            kx    <= '0;
            ky    <= '0;
            ox    <= '0;
            oy    <= '0;
          end
        end
        RUN: begin
          if (!sif.stall) begin
            ifm_addr <= ifm_addr_nxt;
            w_addr   <= w_addr_nxt;
            if (!last_c) c <= c + 1'b1;
            else begin
              c <= '0;
              if (!last_kx) kx <= kx + 1'b1;
              else begin
                kx <= '0;
                if (!last_ky) ky <= ky + 1'b1;
                else begin
                  ky <= '0;
                  if (!last_ox) ox <= ox + 1'b1;
                  else begin
                    ox <= '0;
                    if (!last_oy) oy <= oy + 1'b1;
                    else begin
                      oy    <= '0;
                      state <= DRAIN;
                    end
                  end
                end
              end
            end
          end
        end
        DRAIN: begin
          if (!pending) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Stage 0 is the issue cycle; mac controls tap MEM_LAT, ofm strobe taps MEM_LAT+MAC_LAT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_pipe  <= '0;
      clr_pipe  <= '0;
      pad_pipe  <= '0;
      last_pipe <= '0;
      x_pipe    <= '0;
      y_pipe    <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[MEM_LAT-1:0], issue};
      clr_pipe  <= {clr_pipe[MEM_LAT-1:0], issue && win_first};
      pad_pipe  <= {pad_pipe[MEM_LAT-1:0], issue ? !in_bounds : pad_pipe[0]};
      last_pipe <= {last_pipe[L-1:0], issue && win_last};
      x_pipe    <= {x_pipe[L-1:0], ox};
      y_pipe    <= {y_pipe[L-1:0], oy};
    end
  end

  assign sif.ifm_addr  = ifm_addr;
  assign sif.w_addr    = w_addr;
  assign sif.pad_zero  = pad_pipe[MEM_LAT];
  assign sif.mac_en    = vld_pipe[MEM_LAT];
  assign sif.mac_clr   = clr_pipe[MEM_LAT];
  assign sif.mac_last  = last_pipe[MEM_LAT];
  assign sif.ofm_valid = last_pipe[L];
  assign sif.ofm_x     = x_pipe[L];
  assign sif.ofm_y     = y_pipe[L];
  assign sif.busy      = busy;
  assign sif.done      = done;

`ifdef FIRE_EX3_SCHED_PERF_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                         stall_cnt <= '0;
    else if (state == IDLE && sif.start)             stall_cnt <= '0;
    else if (state == RUN && sif.stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign sif.stall_cnt = stall_cnt;
`endif

endmodule
